// File: rtl/complex_div_seq_pkg.sv
// Shared definitions for the complex-FU divider: opcodes, flag layout, FSM states.
// Also holds small helpers used by the divider and its interface.
package complex_div_seq_pkg;

    localparam int OPCODE_W = 6;
    localparam int FLAGS_W  = 6;

    localparam logic [OPCODE_W-1:0] OP_DIV_L  = 6'h10;
    localparam logic [OPCODE_W-1:0] OP_DIV_H  = 6'h11;
    localparam logic [OPCODE_W-1:0] OP_DIVU_L = 6'h12;
    localparam logic [OPCODE_W-1:0] OP_DIVU_H = 6'h13;

    // Execution-flag bit positions, complex-ALU field order (MSB first).
    localparam int FLG_RSV_HI = 5;
    localparam int FLG_ONE_HI = 4;
    localparam int FLG_IS_L   = 3;
    localparam int FLG_ONE_LO = 2;
    localparam int FLG_EXC    = 1;
    localparam int FLG_RSV_LO = 0;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    function automatic logic is_div_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_DIV_L) || (op == OP_DIV_H) || (op == OP_DIVU_L) || (op == OP_DIVU_H);
    endfunction

    function automatic logic [FLAGS_W-1:0] make_flags(input logic is_l, input logic exc);
        logic [FLAGS_W-1:0] f;
        f             = '0;
        f[FLG_ONE_HI] = 1'b1;
        f[FLG_IS_L]   = is_l;
        f[FLG_ONE_LO] = 1'b1;
        f[FLG_EXC]    = exc;
        return f;
    endfunction

endpackage

// File: rtl/complex_div_seq_if.sv
// Issue-side and writeback-side handshake bundle of the divider.
// valid/ready: a transfer happens on a rising edge where both valid and ready are high.
interface complex_div_seq_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 7,
    parameter int ROB_W  = 7
) ();
    import complex_div_seq_pkg::*;

    logic                valid_i;
    logic                ready_o;
    logic [OPCODE_W-1:0] opcode_i;
    logic [DATA_W-1:0]   data1_i;
    logic [DATA_W-1:0]   data2_i;
    logic [TAG_W-1:0]    tag_i;
    logic [ROB_W-1:0]    rob_i;
    logic                flush_i;
    logic                valid_o;
    logic                wb_ready_i;
    logic [DATA_W-1:0]   result_o;
    logic [FLAGS_W-1:0]  flags_o;
    logic [TAG_W-1:0]    tag_o;
    logic [ROB_W-1:0]    rob_o;

    modport master (
        output valid_i, opcode_i, data1_i, data2_i, tag_i, rob_i, flush_i, wb_ready_i,
        input  ready_o, valid_o, result_o, flags_o, tag_o, rob_o
    );

    modport slave (
        input  valid_i, opcode_i, data1_i, data2_i, tag_i, rob_i, flush_i, wb_ready_i,
        output ready_o, valid_o, result_o, flags_o, tag_o, rob_o
    );

endinterface

// File: rtl/complex_div_seq_div_iter_step.sv
// One radix-2 restoring step: shift {rem,quo} left, trial-subtract the divisor.
module div_iter_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);
    // The shifted remainder needs one extra bit since the divisor may use all W bits.
    logic [W:0]   w_sh;
    logic         w_ge;
    logic [W-1:0] w_diff;

    assign w_sh   = {i_rem, i_quo[W-1]};
    assign w_ge   = (w_sh >= {1'b0, i_div});
    assign w_diff = W'(w_sh - {1'b0, i_div});
    assign o_rem  = w_ge ? w_diff : w_sh[W-1:0];
    assign o_quo  = {i_quo[W-2:0], w_ge};

endmodule

// File: rtl/complex_div_seq.sv
// Iterative signed/unsigned divider: one quotient bit per cycle, sign fix-up, registered writeback packet.
module complex_div_seq
    import complex_div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 7,
    parameter int ROB_W  = 7,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    complex_div_seq_if.slave  bus,
    output state_t            o_dbg_state
);
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_div;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_l;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [TAG_W-1:0]    r_tag_lat;
    logic [ROB_W-1:0]    r_rob_lat;
    logic [DATA_W-1:0]   r_result;
    logic [FLAGS_W-1:0]  r_flags;
    logic [TAG_W-1:0]    r_tag;
    logic [ROB_W-1:0]    r_rob;

    logic                w_accept;
    logic                w_signed;
    logic                w_is_l;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [DATA_W-1:0]   w_rem_n;
    logic [DATA_W-1:0]   w_quo_n;

    assign w_accept   = bus.valid_i && (r_state == IDLE) && is_div_op(bus.opcode_i) && !bus.flush_i;
    assign w_signed   = (bus.opcode_i == OP_DIV_L) || (bus.opcode_i == OP_DIV_H);
    assign w_is_l     = (bus.opcode_i == OP_DIV_L) || (bus.opcode_i == OP_DIVU_L);
    assign w_div_zero = (bus.data2_i == '0);
    assign w_ovf      = w_signed && (bus.data1_i == MIN_VAL) && (bus.data2_i == '1);
    assign w_special  = w_div_zero || w_ovf;

    div_iter_step #(.W(DATA_W)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_n),
        .o_quo (w_quo_n)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = w_special ? DONE : ITER;
            ITER:    if (r_cnt == CNT_W'(1)) w_next_state = FIX;
            FIX:     w_next_state = DONE;
            DONE:    if (bus.wb_ready_i) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        // Flush beats every other transition, including a writeback handshake.
        if (bus.flush_i) w_next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_is_l    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_tag_lat <= '0;
            r_rob_lat <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_tag     <= '0;
            r_rob     <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_is_l    <= w_is_l;
                    r_neg_q   <= w_signed && (bus.data1_i[DATA_W-1] ^ bus.data2_i[DATA_W-1]);
                    r_neg_r   <= w_signed && bus.data1_i[DATA_W-1];
                    r_quo     <= (w_signed && bus.data1_i[DATA_W-1]) ? -bus.data1_i : bus.data1_i;
                    r_div     <= (w_signed && bus.data2_i[DATA_W-1]) ? -bus.data2_i : bus.data2_i;
                    r_rem     <= '0;
                    r_cnt     <= CNT_W'(DATA_W);
                    r_tag_lat <= bus.tag_i;
                    r_rob_lat <= bus.rob_i;
                    // Special cases bypass iteration and load the packet directly.
                    if (w_special) begin
                        if (w_is_l) r_result <= w_div_zero ? '1 : MIN_VAL;
                        else        r_result <= w_div_zero ? bus.data1_i : '0;
                        r_flags <= make_flags(w_is_l, w_div_zero);
                        r_tag   <= bus.tag_i;
                        r_rob   <= bus.rob_i;
                    end
                end
                ITER: begin
                    r_rem <= w_rem_n;
                    r_quo <= w_quo_n;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIX: begin
                    if (r_is_l) r_result <= r_neg_q ? -r_quo : r_quo;
                    else        r_result <= r_neg_r ? -r_rem : r_rem;
                    r_flags <= make_flags(r_is_l, 1'b0);
                    r_tag   <= r_tag_lat;
                    r_rob   <= r_rob_lat;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = (r_state == IDLE);
    assign bus.valid_o  = (r_state == DONE);
    assign bus.result_o = r_result;
    assign bus.flags_o  = r_flags;
    assign bus.tag_o    = r_tag;
    assign bus.rob_o    = r_rob;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_complex_div_seq.sv
// Directed bench for complex_div_seq: vector table plus hand-written handshake,
// flush and reset sequences.
module tb_complex_div_seq;
    import complex_div_seq_pkg::*;

    logic   clk;
    logic   reset;
    state_t dbg_state;
    int     checks;
    int     failures;
    logic [31:0] exp_q[$];

    complex_div_seq_if #(.DATA_W(32), .TAG_W(7), .ROB_W(7)) bus ();

    complex_div_seq #(.DATA_W(32), .TAG_W(7), .ROB_W(7), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp_res;
        logic [5:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs[18];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver: called at a negedge, returns at the negedge after the accept edge
    task automatic issue(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [6:0] tg, input logic [6:0] rb);
        bus.valid_i  = 1'b1;
        bus.opcode_i = op;
        bus.data1_i  = d1;
        bus.data2_i  = d2;
        bus.tag_i    = tg;
        bus.rob_i    = rb;
        @(negedge clk);
        bus.valid_i  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) seen++;
        end
    endtask

    task automatic run_vec(input string nm, input logic [5:0] op, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] er, input logic [5:0] ef,
                           input int el, input logic [6:0] tg, input logic [6:0] rb);
        int lat;
        logic [31:0] exp_r;
        check({nm, ".ready_before"}, 64'(bus.ready_o), 64'(1));
        exp_q.push_back(er);
        issue(op, d1, d2, tg, rb);
        wait_valid(lat);
        check({nm, ".latency"}, 64'(lat), 64'(el));
        exp_r = exp_q.pop_front();
        check({nm, ".result"}, 64'(bus.result_o), 64'(exp_r));
        check({nm, ".flags"}, 64'(bus.flags_o), 64'(ef));
        check({nm, ".tag"}, 64'(bus.tag_o), 64'(tg));
        check({nm, ".rob"}, 64'(bus.rob_o), 64'(rb));
        @(negedge clk);
        check({nm, ".ready_after"}, 64'(bus.ready_o), 64'(1));
        check({nm, ".valid_after"}, 64'(bus.valid_o), 64'(0));
    endtask

    initial begin
        int lat;
        int seen;
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        bus.valid_i  = 1'b0;
        bus.opcode_i = '0;
        bus.data1_i  = '0;
        bus.data2_i  = '0;
        bus.tag_i    = '0;
        bus.rob_i    = '0;
        bus.flush_i  = 1'b0;
        bus.wb_ready_i = 1'b1;

        // flags: L ok=1C, H ok=14, L div0=1E, H div0=16
        vecs[0]  = '{OP_DIVU_L, 32'd100,        32'd7,          32'd14,         6'h1C, 34};
        vecs[1]  = '{OP_DIVU_H, 32'd100,        32'd7,          32'd2,          6'h14, 34};
        vecs[2]  = '{OP_DIV_L,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  6'h1C, 34};
        vecs[3]  = '{OP_DIV_H,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  6'h14, 34};
        vecs[4]  = '{OP_DIV_L,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  6'h1C, 34};
        vecs[5]  = '{OP_DIV_H,  32'd7,          32'hFFFF_FFFE,  32'd1,          6'h14, 34};
        vecs[6]  = '{OP_DIV_L,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  6'h1E, 1};
        vecs[7]  = '{OP_DIV_H,  32'h0000_1234,  32'd0,          32'h0000_1234,  6'h16, 1};
        vecs[8]  = '{OP_DIV_L,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  6'h1C, 1};
        vecs[9]  = '{OP_DIV_H,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          6'h14, 1};
        vecs[10] = '{OP_DIVU_L, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  6'h1C, 34};
        vecs[11] = '{OP_DIVU_H, 32'hFFFF_FFFF,  32'h10,         32'hF,          6'h14, 34};
        vecs[12] = '{OP_DIVU_L, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          6'h1C, 34};
        vecs[13] = '{OP_DIVU_H, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  6'h14, 34};
        vecs[14] = '{OP_DIV_L,  32'h8000_0000,  32'd2,          32'hC000_0000,  6'h1C, 34};
        vecs[15] = '{OP_DIV_L,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         6'h1C, 34};
        vecs[16] = '{OP_DIV_H,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  6'h14, 34};
        vecs[17] = '{OP_DIVU_H, 32'd5,          32'd9,          32'd5,          6'h14, 34};

        repeat (3) @(negedge clk);
        check("rst.ready",  64'(bus.ready_o),  64'(1));
        check("rst.valid",  64'(bus.valid_o),  64'(0));
        check("rst.result", 64'(bus.result_o), 64'(0));
        check("rst.flags",  64'(bus.flags_o),  64'(0));
        check("rst.tag",    64'(bus.tag_o),    64'(0));
        check("rst.rob",    64'(bus.rob_o),    64'(0));
        check("rst.state",  64'(dbg_state),    64'(IDLE));
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
                    vecs[i].exp_res, vecs[i].exp_flags, vecs[i].exp_lat,
                    7'(i + 3), 7'((i * 5 + 1) % 128));
        end

        // writeback backpressure: packet held stable for 5 cycles
        bus.wb_ready_i = 1'b0;
        issue(OP_DIVU_H, 32'd100, 32'd7, 7'h55, 7'h2A);
        wait_valid(lat);
        check("bp.latency", 64'(lat), 64'(34));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp.valid%0d", k),  64'(bus.valid_o),  64'(1));
            check($sformatf("bp.ready%0d", k),  64'(bus.ready_o),  64'(0));
            check($sformatf("bp.result%0d", k), 64'(bus.result_o), 64'(2));
            check($sformatf("bp.tag%0d", k),    64'(bus.tag_o),    64'(7'h55));
            check($sformatf("bp.rob%0d", k),    64'(bus.rob_o),    64'(7'h2A));
        end
        bus.wb_ready_i = 1'b1;
        @(negedge clk);
        check("bp.release_ready", 64'(bus.ready_o), 64'(1));
        check("bp.release_valid", 64'(bus.valid_o), 64'(0));
        run_vec("bp.next", OP_DIVU_L, 32'd50, 32'd5, 32'd10, 6'h1C, 34, 7'h11, 7'h22);

        // flush in ITER cycle 10
        issue(OP_DIVU_L, 32'd1000, 32'd3, 7'h01, 7'h02);
        repeat (9) @(negedge clk);
        check("flush_iter.state_before", 64'(dbg_state), 64'(ITER));
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_iter.ready", 64'(bus.ready_o), 64'(1));
        check("flush_iter.valid", 64'(bus.valid_o), 64'(0));
        count_valid(40, seen);
        check("flush_iter.no_output", 64'(seen), 64'(0));

        // flush wins over a writeback handshake in DONE
        issue(OP_DIV_L, 32'h1234, 32'd0, 7'h33, 7'h44);
        check("flush_done.valid_before", 64'(bus.valid_o), 64'(1));
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_done.valid", 64'(bus.valid_o), 64'(0));
        check("flush_done.ready", 64'(bus.ready_o), 64'(1));

        // flush together with valid in IDLE blocks the accept
        bus.valid_i  = 1'b1;
        bus.opcode_i = OP_DIV_L;
        bus.data1_i  = 32'd9;
        bus.data2_i  = 32'd0;
        bus.flush_i  = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_idle.state", 64'(dbg_state), 64'(IDLE));
        count_valid(5, seen);
        check("flush_idle.no_output", 64'(seen), 64'(0));

        // illegal opcode is ignored
        bus.valid_i  = 1'b1;
        bus.opcode_i = 6'h00;
        bus.data2_i  = 32'd0;
        @(negedge clk);
        check("illegal.ready", 64'(bus.ready_o), 64'(1));
        bus.valid_i = 1'b0;
        count_valid(5, seen);
        check("illegal.no_output", 64'(seen), 64'(0));

        // reset mid-ITER clears the last packet registers
        issue(OP_DIVU_L, 32'd100, 32'd7, 7'h7F, 7'h7E);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid.result", 64'(bus.result_o), 64'(0));
        check("rst_mid.flags",  64'(bus.flags_o),  64'(0));
        check("rst_mid.tag",    64'(bus.tag_o),    64'(0));
        check("rst_mid.rob",    64'(bus.rob_o),    64'(0));
        check("rst_mid.valid",  64'(bus.valid_o),  64'(0));
        check("rst_mid.ready",  64'(bus.ready_o),  64'(1));
        reset = 1'b1;
        count_valid(40, seen);
        check("rst_mid.no_output", 64'(seen), 64'(0));
        run_vec("post_rst", OP_DIVU_L, 32'd100, 32'd7, 32'd14, 6'h1C, 34, 7'h05, 7'h06);

        check("scoreboard.empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
